// File: rtl/fns_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fns_pkg
//  Description : Fibonacci-numeral-system helpers shared by the CAC decoder:
//                Fibonacci terms, per-bit weights (plain FNS or IDP mapping),
//                weight sum and decoded-value width.
//  Revision    : 1.0 - initial release
// ============================================================================
package fns_pkg;

  // k-th Fibonacci number with fns(1) = fns(2) = 1
  function automatic int fns(input int k);
    int a;
    int b;
    int t;
    a = 1;
    b = 1;
    if (k <= 2) return 1;
    for (int j = 3; j <= k; j++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  // Weight of codeword bit i; MODE 1 swaps in the IDP mapping on the top three bits
  function automatic int fns_weight(input int i, input int n, input int mode);
    if (mode == 0)                  return fns(i + 1);
    if (i == n - 1)                 return fns(n - 1);
    if ((i == n - 2) || (i == n - 3)) return fns(n);
    return fns(i + 1);
  endfunction

  // Sum of all weights: the largest value a legal codeword can decode to
  function automatic int fns_wsum(input int n, input int mode);
    int s;
    s = 0;
    for (int i = 0; i < n; i++) s = s + fns_weight(i, n, mode);
    return s;
  endfunction

  // Bits needed to hold any value 0..weight sum
  function automatic int fns_width(input int n, input int mode);
    return $clog2(fns_wsum(n, mode) + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fns_grp_dec.sv
`default_nettype none
// ============================================================================
//  Module      : fns_grp_dec
//  Description : Single-group FNS/IDP codeword decoder. Stage 1 holds the two
//                half-word partial sums, stage 2 the final sum and its
//                out-of-range flag. Stage advance is controlled externally.
//  Revision    : 1.0 - initial release
// ============================================================================
module fns_grp_dec
  import fns_pkg::*;
#(
  parameter int N       = 7,
  parameter int MODE    = 1,
  parameter int DW      = fns_width(N, MODE),
  parameter int ERR_MAX = fns_wsum(N, MODE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en1,
  input  logic          i_en2,
  input  logic [N-1:0]  i_code,
  output logic [DW-1:0] o_sum,
  output logic          o_err
);

  localparam int HALF = N / 2;

  logic [DW-1:0] w_lo;
  logic [DW-1:0] w_hi;
  logic [DW-1:0] w_sum;
  logic [DW-1:0] r_lo;
  logic [DW-1:0] r_hi;

  // Weighted partial sums of the low and high halves of the codeword
  always_comb begin
    w_lo = '0;
    w_hi = '0;
    for (int i = 0; i < N; i++) begin
      if (i_code[i]) begin
        if (i < HALF) w_lo = w_lo + DW'(fns_weight(i, N, MODE));
        else          w_hi = w_hi + DW'(fns_weight(i, N, MODE));
      end
    end
  end

  // Stage 1: capture partial sums when the beat is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lo <= '0;
      r_hi <= '0;
    end else if (i_en1) begin
      r_lo <= w_lo;
      r_hi <= w_hi;
    end
  end

  // Sum cannot overflow DW: DW is sized for the full weight sum
  assign w_sum = r_lo + r_hi;

  // Stage 2: final value and out-of-range flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_sum <= '0;
      o_err <= 1'b0;
    end else if (i_en2) begin
      o_sum <= w_sum;
      o_err <= (32'(w_sum) > ERR_MAX);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fns_cac_dec_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fns_cac_dec_pipe
//  Description : Pipelined multi-group FNS/IDP crosstalk-avoidance decoder
//                with valid/ready flow control, per-group range flags and a
//                saturating error counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module fns_cac_dec_pipe
  import fns_pkg::*;
#(
  parameter  int N       = 7,
  parameter  int CH      = 4,
  parameter  int MODE    = 1,
  localparam int DW      = fns_width(N, MODE),
  parameter  int ERR_MAX = fns_wsum(N, MODE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH*N-1:0]  in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH*DW-1:0] out_data,
  output logic [CH-1:0]    out_err,
  input  logic             err_clr,
  output logic [15:0]      err_cnt
);

  logic        r_v1;
  logic        r_v2;
  logic        w_adv1;
  logic        w_adv2;
  logic        w_acc;
  logic        w_hs;
  logic [16:0] w_pop;
  logic [16:0] w_cnt_sum;
  logic [15:0] r_cnt;

  // No skid buffer: readiness ripples straight back from out_ready
  assign w_adv2   = !r_v2 || out_ready;
  assign w_adv1   = !r_v1 || w_adv2;
  assign in_ready = w_adv1;
  assign w_acc    = in_valid && w_adv1;
  assign w_hs     = r_v2 && out_ready;

  // Stage valid bits move forward only when the downstream stage frees up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      if (w_adv1) r_v1 <= in_valid;
      if (w_adv2) r_v2 <= r_v1;
    end
  end

  assign out_valid = r_v2;

  // One decoder per group; stage 2 only loads when stage 1 holds a beat
  for (genvar g = 0; g < CH; g++) begin : g_grp
    fns_grp_dec #(
      .N       (N),
      .MODE    (MODE),
      .DW      (DW),
      .ERR_MAX (ERR_MAX)
    ) u_dec (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en1  (w_acc),
      .i_en2  (w_adv2 && r_v1),
      .i_code (in_code[g*N +: N]),
      .o_sum  (out_data[g*DW +: DW]),
      .o_err  (out_err[g])
    );
  end

  // Number of flagged groups in the beat currently on the output
  always_comb begin
    w_pop = '0;
    for (int g = 0; g < CH; g++) w_pop = w_pop + 17'(out_err[g]);
  end

  assign w_cnt_sum = {1'b0, r_cnt} + w_pop;

  // Saturating error counter; clear wins over a coincident handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (err_clr) begin
      r_cnt <= '0;
    end else if (w_hs) begin
      r_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end
  end

  assign err_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fns_cac_dec_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fns_cac_dec_pipe
//  Description : Scoreboard bench for fns_cac_dec_pipe (IDP, 4 groups,
//                ERR_MAX=30) plus a plain-FNS single-group instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fns_cac_dec_pipe;

  typedef struct packed {
    logic [23:0] d;
    logic [3:0]  e;
    int          cyc;
  } item_t;

  typedef struct packed {
    logic [5:0] d;
    logic       e;
  } bitem_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [27:0] in_code;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic [3:0]  out_err;
  logic        err_clr;
  logic [15:0] err_cnt;

  logic        b_valid;
  logic        b_in_ready;
  logic [6:0]  b_code;
  logic        b_ovalid;
  logic        b_ordy;
  logic [5:0]  b_data;
  logic [0:0]  b_err;
  logic        b_clr;
  logic [15:0] b_cnt;

  bit bp_on    = 1'b0;
  bit bp_val   = 1'b1;
  bit or_force = 1'b1;
  bit lat_chk  = 1'b1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  item_t  q[$];
  bitem_t qb[$];

  assign out_ready = bp_on ? bp_val : or_force;
  assign b_ordy    = 1'b1;
  assign b_clr     = 1'b0;

  fns_cac_dec_pipe #(.N(7), .CH(4), .MODE(1), .ERR_MAX(30)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .err_clr   (err_clr),
    .err_cnt   (err_cnt)
  );

  fns_cac_dec_pipe #(.N(7), .CH(1), .MODE(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_valid),
    .in_ready  (b_in_ready),
    .in_code   (b_code),
    .out_valid (b_ovalid),
    .out_ready (b_ordy),
    .out_data  (b_data),
    .out_err   (b_err),
    .err_clr   (b_clr),
    .err_cnt   (b_cnt)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready pattern 1,0,0,1 repeating while backpressure is enabled
  initial begin
    int k = 0;
    forever begin
      @(negedge clk);
      bp_val = ((k % 4) == 0) || ((k % 4) == 3);
      k++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference decoder for IDP N=7 (weights bit0..bit6: 1,1,2,3,13,13,8)
  function automatic item_t model(input logic [27:0] c);
    item_t r;
    int    w[7];
    int    v;
    w = '{1, 1, 2, 3, 13, 13, 8};
    r = '0;
    for (int g = 0; g < 4; g++) begin
      v = 0;
      for (int b = 0; b < 7; b++) if (c[g*7+b]) v += w[b];
      r.d[g*6 +: 6] = 6'(v);
      r.e[g]        = (v > 30);
    end
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the beat is accepted
  task automatic send(input logic [27:0] c, input logic [23:0] ed, input logic [3:0] ee);
    bit    done  = 1'b0;
    int    guard = 0;
    item_t it;
    in_valid = 1'b1;
    in_code  = c;
    while (!done) begin
      #4;
      if (in_ready) begin
        it.d   = ed;
        it.e   = ee;
        it.cyc = cyc;
        q.push_back(it);
        done = 1'b1;
      end else if (guard++ > 50) begin
        total++;
        bad++;
        $display("FAIL send_timeout: actual=in_ready_low required=accept");
        done = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic sendb(input logic [6:0] c, input logic [5:0] ed);
    bitem_t it;
    b_valid = 1'b1;
    b_code  = c;
    #4;
    if (b_in_ready) begin
      it.d = ed;
      it.e = 1'b0;
      qb.push_back(it);
    end else begin
      total++;
      bad++;
      $display("FAIL b_accept: actual=0 required=1");
    end
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int g = 0;
    while ((q.size() != 0 || qb.size() != 0) && g < 60) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (q.size() != 0 || qb.size() != 0) begin
      bad++;
      $display("FAIL drain: actual=%0d pending required=0", q.size() + qb.size());
      q.delete();
      qb.delete();
    end
  endtask

  // Monitor for the main instance: in_ready, stall stability, ordered data
  initial begin
    item_t       it;
    logic [23:0] hold_d;
    logic [3:0]  hold_e;
    bit          stalled = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        chk("in_ready", 32'(in_ready), 32'(!(q.size() >= 2 && !out_ready)));
        if (stalled) begin
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_data", 32'(out_data), 32'(hold_d));
          chk("stall_err", 32'(out_err), 32'(hold_e));
        end
        if (out_valid && out_ready) begin
          stalled = 1'b0;
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: actual=%0h required=none", out_data);
          end else begin
            it = q.pop_front();
            chk("out_data", 32'(out_data), 32'(it.d));
            chk("out_err", 32'(out_err), 32'(it.e));
            if (lat_chk) chk("latency", 32'(cyc - it.cyc), 32'd2);
          end
        end else if (out_valid) begin
          stalled = 1'b1;
          hold_d  = out_data;
          hold_e  = out_err;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  // Monitor for the plain-FNS instance
  initial begin
    bitem_t it;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && b_ovalid) begin
        if (qb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL b_unexpected: actual=%0h required=none", b_data);
        end else begin
          it = qb.pop_front();
          chk("b_data", 32'(b_data), 32'(it.d));
          chk("b_err", 32'(b_err), 32'(it.e));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    item_t m;
    logic [27:0] c;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_code  = '0;
    err_clr  = 1'b0;
    b_valid  = 1'b0;
    b_code   = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Back-to-back directed beats; group0 varies, groups 1..3 fixed (0, 7, 13)
    send({7'h10, 7'h0F, 7'h00, 7'h7F}, {6'd13, 6'd7, 6'd0, 6'd41}, 4'b0001);
    send({7'h10, 7'h0F, 7'h00, 7'h01}, {6'd13, 6'd7, 6'd0, 6'd1},  4'b0000);
    send({7'h10, 7'h0F, 7'h00, 7'h40}, {6'd13, 6'd7, 6'd0, 6'd8},  4'b0000);
    send({7'h10, 7'h0F, 7'h00, 7'h30}, {6'd13, 6'd7, 6'd0, 6'd26}, 4'b0000);
    drain();
    chk("err_cnt_t1", 32'(err_cnt), 32'd1);

    // Plain FNS: 7F -> 33 (equal to ERR_MAX, no flag), 50 -> 18, 00 -> 0
    sendb(7'h7F, 6'd33);
    sendb(7'h50, 6'd18);
    sendb(7'h00, 6'd0);
    drain();
    chk("b_err_cnt", 32'(b_cnt), 32'd0);

    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr_idle", 32'(err_cnt), 32'd0);

    // All groups out of range, then the same beat with clear on its handshake
    send({4{7'h7F}}, {4{6'd41}}, 4'hF);
    drain();
    chk("err_cnt_4", 32'(err_cnt), 32'd4);
    send({4{7'h7F}}, {4{6'd41}}, 4'hF);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    drain();
    chk("err_cnt_clr_hs", 32'(err_cnt), 32'd0);

    // Backpressure with random input gaps
    lat_chk = 1'b0;
    bp_on   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      idle($urandom_range(0, 1));
      for (int g = 0; g < 4; g++) c[g*7 +: 7] = 7'(i*4 + g + 1);
      m = model(c);
      send(c, m.d, m.e);
    end
    drain();
    bp_on   = 1'b0;
    lat_chk = 1'b1;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // Preload 16383*4 + 2 = 0xFFFE, then +3 saturates
    repeat (16383) send({4{7'h7F}}, {4{6'd41}}, 4'hF);
    send({7'h00, 7'h00, 7'h7F, 7'h7F}, {6'd0, 6'd0, 6'd41, 6'd41}, 4'b0011);
    drain();
    chk("err_cnt_fffe", 32'(err_cnt), 32'h0000FFFE);
    send({7'h00, 7'h7F, 7'h7F, 7'h7F}, {6'd0, 6'd41, 6'd41, 6'd41}, 4'b0111);
    drain();
    chk("err_cnt_sat", 32'(err_cnt), 32'h0000FFFF);
    send({4{7'h7F}}, {4{6'd41}}, 4'hF);
    drain();
    chk("err_cnt_sat_hold", 32'(err_cnt), 32'h0000FFFF);

    // Two beats stuck in the pipe, then asynchronous reset mid-cycle
    or_force = 1'b0;
    send({4{7'h7F}}, {4{6'd41}}, 4'hF);
    send({4{7'h7F}}, {4{6'd41}}, 4'hF);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_out_err", 32'(out_err), 32'd0);
    chk("arst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    or_force = 1'b1;
    #1;
    chk("arel_in_ready", 32'(in_ready), 32'd1);
    chk("arel_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    send({7'h01, 7'h40, 7'h30, 7'h00}, {6'd1, 6'd8, 6'd26, 6'd0}, 4'b0000);
    drain();
    chk("arel_err_cnt", 32'(err_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fns_cac_dec_pipe.md
Name: fns_cac_dec_pipe

Overview:
- Parametrised, pipelined successor to the single-group combinational FNS/IDP crosstalk-avoidance decoder.
- Decodes CH parallel N-bit CAC codeword groups into binary data per beat using Fibonacci-numeral-system weights, with a selectable weight mapping (plain FNS or IDP).
- Uses a valid/ready handshake, a 2-stage pipeline, per-group out-of-range flagging and a saturating error counter.
- Sits at the receive side of the on-chip bus, between the wire-capture register and the data sink.

Parameters:
- N, 7, codeword bits per group (N >= 4).
- CH, 4, groups decoded per beat.
- MODE, 1: 0 = plain FNS; 1 = IDP weight mapping.
- DW, fns_width(N,MODE), decoded bits per group = clog2(weight sum + 1). Derived, not overridden.
- ERR_MAX, weight sum, largest legal decoded value. A group whose value exceeds it sets its error flag.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- in_code  in  CH*N  codewords; group g = in_code[g*N +: N].
- out_valid  out  1  output beat valid.
- out_ready  in  1  sink accepts the output beat.
- out_data  out  CH*DW  decoded values; group g = out_data[g*DW +: DW].
- out_err  out  CH  per-group out-of-range flag, aligned with out_data.
- err_clr  in  1  synchronous clear of err_cnt.
- err_cnt  out  16  saturating count of flagged groups.

Behaviour:
- Fibonacci sequence: fns(1)=1, fns(2)=1, fns(k)=fns(k-1)+fns(k-2).
- MODE 0 weights: bit i weight = fns(i+1).
- MODE 1 weights:
  - bit N-1 weight = fns(N-1);
  - bits N-2 and N-3 weight = fns(N);
  - bit i < N-3 weight = fns(i+1).
- Decoded value = sum of code bits times weights, exact, computed in DW bits.
- Pipeline:
  - Stage 1 registers two partial sums per group: bits [N/2-1:0] and bits [N-1:N/2].
  - Stage 2 registers the final sum, out_err[g] = (sum > ERR_MAX), and out_valid.
- Latency is 2 cycles from an accepted input to out_valid when out_ready is held high. Throughput is 1 beat/cycle.
- Flow control:
  - Stage 2 advances when !out_valid || out_ready.
  - Stage 1 advances when stage 1 is empty or stage 2 advances.
  - in_ready = stage 1 empty || stage 2 advances (combinational from out_ready; no skid buffer).
  - Input is accepted on in_valid && in_ready.
- While out_valid && !out_ready, out_data and out_err hold stable. Data is never dropped or duplicated.
- err_cnt:
  - On each output handshake (out_valid && out_ready), add popcount(out_err), saturating at 16'hFFFF.
  - err_clr has priority: when it coincides with a handshake, the counter becomes 0 and that beat's errors are discarded.
- Reset (asserted at any time, including mid-stream): all pipeline valids, out_valid, out_data, out_err and err_cnt go to 0 immediately. In-flight beats are lost. in_ready reads 1 after reset release.
- A code of all zeros decodes to 0 with no error.

Decomposition:
- Shared package fns_pkg:
  - function fns(k);
  - function fns_weight(i, N, MODE);
  - function fns_width(N, MODE) giving DW;
  - weight-sum function.
  - The existing fixed-width FNS constants header is superseded by it.
- One sub-module fns_grp_dec (single group, 2 registered stages with external stage-advance enables), instantiated CH times in a generate loop.
- The top level owns the handshake and err_cnt.

Test Plan:
- N=7, MODE=1, CH=1, out_ready=1 (weights 1,1,2,3,13,13,8 from bit0 to bit6; sum 41; DW=6).
  - Drive codes 7'h7F, 7'h01, 7'h40, 7'h30 on consecutive cycles.
  - Expect outputs 41, 1, 8, 26 on cycles 2 to 5, with out_err=0.
- MODE=0, N=7: code 7'h7F -> 33, code 7'h50 -> 18; DW=6.
- ERR_MAX=30, N=7, MODE=1, CH=4, all four groups 7'h7F -> out_err=4'hF and err_cnt=4.
  - A second identical beat with err_clr high on its handshake cycle -> err_cnt=0.
- Backpressure:
  - Stream 10 incrementing codes with out_ready toggling 1,0,0,1 and random in_valid.
  - Expect exact in-order outputs, stable out_data while stalled, and in_ready=0 only when both stages are full and out_ready=0.
- Preload err_cnt to 16'hFFFE via forced errors, then one beat with 3 errors -> err_cnt=16'hFFFF, saturated.
- Assert rst_n low with 2 beats in flight -> out_valid=0, out_data=0 and err_cnt=0 asynchronously (before the next clk edge).
  - After release, the first new beat emerges 2 cycles after acceptance.
